// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bundle: PC register side, instruction-memory request/response,
// and the decode-side valid/ready handshake.
interface instr_fetch_unit_if #(
  parameter int WORDSIZE = 32
);
  logic [WORDSIZE-1:0] pc;
  logic                redirect;
  logic                pc_advance;

  logic                imem_req_valid;
  logic [WORDSIZE-1:0] imem_req_addr;
  logic                imem_req_ready;
  logic                imem_rsp_valid;
  logic [WORDSIZE-1:0] imem_rsp_data;

  logic                instr_valid;
  logic [WORDSIZE-1:0] instr;
  logic [WORDSIZE-1:0] instr_pc;
  logic                instr_fault;
  logic                dec_ready;

  modport master (
    input  pc, redirect, imem_req_ready, imem_rsp_valid, imem_rsp_data, dec_ready,
    output pc_advance, imem_req_valid, imem_req_addr,
           instr_valid, instr, instr_pc, instr_fault
  );

  modport slave (
    output pc, redirect, imem_req_ready, imem_rsp_valid, imem_rsp_data, dec_ready,
    input  pc_advance, imem_req_valid, imem_req_addr,
           instr_valid, instr, instr_pc, instr_fault
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: one outstanding word fetch at a time, presents the
// result to decode and squashes fetches that a redirect has made stale.
module instr_fetch_unit #(
  parameter int                  WORDSIZE  = 32,
  parameter logic [WORDSIZE-1:0] NOP_INSTR = WORDSIZE'(32'h0000_0013)
) (
  input  logic              clk,
  input  logic              reset,
  instr_fetch_unit_if.master bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    OUT  = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_next;

  logic [WORDSIZE-1:0] r_req_pc;
  logic                r_drop;
  logic [WORDSIZE-1:0] r_instr;
  logic [WORDSIZE-1:0] r_instr_pc;
  logic                r_instr_fault;

  logic                w_aligned;
  logic                w_req_valid;
  logic                w_instr_valid;
  logic                w_pc_advance;
  logic                w_latch_req;
  logic                w_capture_rsp;
  logic                w_capture_fault;
  logic                w_drop_set;
  logic                w_drop_clr;

  assign w_aligned = (bus.pc[1:0] == 2'b00);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // A misaligned PC under redirect is stale, so REQ holds rather than faulting.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: w_next = REQ;
      REQ: begin
        if (w_aligned) begin
          if (bus.imem_req_ready) w_next = WAIT;
        end else if (!bus.redirect) begin
          w_next = OUT;
        end
      end
      WAIT: begin
        if (bus.imem_rsp_valid) begin
          w_next = (r_drop || bus.redirect) ? REQ : OUT;
        end
      end
      OUT: begin
        if (bus.redirect || bus.dec_ready) w_next = REQ;
      end
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_req_valid     = 1'b0;
    w_instr_valid   = 1'b0;
    w_pc_advance    = 1'b0;
    w_latch_req     = 1'b0;
    w_capture_rsp   = 1'b0;
    w_capture_fault = 1'b0;
    w_drop_set      = 1'b0;
    w_drop_clr      = 1'b0;
    unique case (r_state)
      REQ: begin
        w_req_valid     = w_aligned;
        w_latch_req     = w_aligned && bus.imem_req_ready;
        w_capture_fault = !w_aligned && !bus.redirect;
      end
      WAIT: begin
        w_capture_rsp = bus.imem_rsp_valid && !r_drop && !bus.redirect;
        w_drop_clr    = bus.imem_rsp_valid;
        w_drop_set    = !bus.imem_rsp_valid && bus.redirect;
      end
      OUT: begin
        w_instr_valid = 1'b1;
        w_pc_advance  = bus.dec_ready && !bus.redirect;
      end
      default: ;
    endcase
  end

  // A request accepted alongside a redirect is already stale: mark it for dropping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_req_pc      <= '0;
      r_drop        <= 1'b0;
      r_instr       <= NOP_INSTR;
      r_instr_pc    <= '0;
      r_instr_fault <= 1'b0;
    end else begin
      if (w_latch_req) begin
        r_req_pc <= bus.pc;
        r_drop   <= bus.redirect;
      end else if (w_drop_set) begin
        r_drop <= 1'b1;
      end else if (w_drop_clr) begin
        r_drop <= 1'b0;
      end

      if (w_capture_rsp) begin
        r_instr       <= bus.imem_rsp_data;
        r_instr_pc    <= r_req_pc;
        r_instr_fault <= 1'b0;
      end else if (w_capture_fault) begin
        r_instr       <= NOP_INSTR;
        r_instr_pc    <= bus.pc;
        r_instr_fault <= 1'b1;
      end
    end
  end

  assign bus.imem_req_valid = w_req_valid;
  assign bus.imem_req_addr  = w_req_valid ? bus.pc : '0;
  assign bus.instr_valid    = w_instr_valid;
  assign bus.instr          = r_instr;
  assign bus.instr_pc       = r_instr_pc;
  assign bus.instr_fault    = r_instr_fault;
  assign bus.pc_advance     = w_pc_advance;

endmodule
